// File: rtl/psa_simd_pipe.sv
// psa_simd_pipe: two-stage pipelined partitioned (SIMD) adder/subtractor.
// A WIDTH-bit operand pair is split into independent 4-, 8- or 16-bit lanes,
// chosen per transaction. Each lane reports signed overflow and can optionally
// saturate. Sticky error and a saturating overflow counter are kept for status.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = not stalled)
//   A, B                  operands
//   mode                  00 = 4-bit, 01 = 8-bit, 10 = 16-bit, 11 = as 00
//   sub, sat              subtract select, per-lane saturation enable
//   out_valid / out_ready result handshake
//   Sum, lane_ovfl, Error lane results, per-4-bit-slot overflow, OR of overflow
//   err_sticky, ovfl_count, clr_err  status and its clear
module psa_simd_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         mode,
  input  logic               sub,
  input  logic               sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Sum,
  output logic [WIDTH/4-1:0] lane_ovfl,
  output logic               Error,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   ovfl_count,
  input  logic               clr_err
);

  localparam int NS = WIDTH / 4;

  // Stage 1 registers
  logic             s1Valid_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       mode_q;
  logic             sub_q, sat_q;

  // Stage 2 registers
  logic             s2Valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [NS-1:0]    ovfl_q, ovfl_d;
  logic             error_q;

  // Status registers
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             stall;
  logic             consume;
  logic [WIDTH-1:0] bEff;
  logic [WIDTH-1:0] sum4, sum8, sum16;
  logic [NS-1:0]    ovf4, ovf8, ovf16;

  assign stall    = s2Valid_q && !out_ready;
  assign consume  = s2Valid_q && out_ready;
  assign in_ready = !stall;

  // Subtraction is A + ~B + 1 per lane; the +1 is injected as each lane's carry-in.
  assign bEff = sub_q ? ~b_q : b_q;

  // 4-bit lanes. Overflow: operand signs equal and result sign differs.
  // The saturation value follows the operand sign, since both signs agree on overflow.
  always_comb begin : lane4
    logic [3:0] r;
    logic       o;
    r    = '0;
    o    = 1'b0;
    sum4 = '0;
    ovf4 = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      r = a_q[4*i +: 4] + bEff[4*i +: 4] + {3'b000, sub_q};
      o = (a_q[4*i+3] == bEff[4*i+3]) && (r[3] != a_q[4*i+3]);
      if (o && sat_q) r = a_q[4*i+3] ? 4'b1000 : 4'b0111;
      sum4[4*i +: 4] = r;
      ovf4[i]        = o;
    end
  end

  // 8-bit lanes; an overflowing lane flags both of its 4-bit slots.
  always_comb begin : lane8
    logic [7:0] r;
    logic       o;
    r    = '0;
    o    = 1'b0;
    sum8 = '0;
    ovf8 = '0;
    for (int i = 0; i < WIDTH / 8; i++) begin
      r = a_q[8*i +: 8] + bEff[8*i +: 8] + {7'd0, sub_q};
      o = (a_q[8*i+7] == bEff[8*i+7]) && (r[7] != a_q[8*i+7]);
      if (o && sat_q) r = a_q[8*i+7] ? 8'h80 : 8'h7F;
      sum8[8*i +: 8] = r;
      ovf8[2*i +: 2] = {2{o}};
    end
  end

  // 16-bit lanes; an overflowing lane flags all four of its slots.
  always_comb begin : lane16
    logic [15:0] r;
    logic        o;
    r     = '0;
    o     = 1'b0;
    sum16 = '0;
    ovf16 = '0;
    for (int i = 0; i < WIDTH / 16; i++) begin
      r = a_q[16*i +: 16] + bEff[16*i +: 16] + {15'd0, sub_q};
      o = (a_q[16*i+15] == bEff[16*i+15]) && (r[15] != a_q[16*i+15]);
      if (o && sat_q) r = a_q[16*i+15] ? 16'h8000 : 16'h7FFF;
      sum16[16*i +: 16] = r;
      ovf16[4*i +: 4]   = {4{o}};
    end
  end

  // Lane-width select; the reserved mode 11 falls through to 4-bit lanes.
  always_comb begin
    sum_d  = sum4;
    ovfl_d = ovf4;
    case (mode_q)
      2'b01: begin
        sum_d  = sum8;
        ovfl_d = ovf8;
      end
      2'b10: begin
        sum_d  = sum16;
        ovfl_d = ovf16;
      end
      default: ;
    endcase
  end

  // Pipeline advance. Both stages freeze together while the result is stalled,
  // so outputs stay stable. Bubbles clear the result so Error reads 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      sub_q     <= 1'b0;
      sat_q     <= 1'b0;
      s2Valid_q <= 1'b0;
      sum_q     <= '0;
      ovfl_q    <= '0;
      error_q   <= 1'b0;
    end else if (!stall) begin
      s1Valid_q <= in_valid;
      a_q       <= A;
      b_q       <= B;
      mode_q    <= mode;
      sub_q     <= sub;
      sat_q     <= sat;
      s2Valid_q <= s1Valid_q;
      sum_q     <= s1Valid_q ? sum_d : '0;
      ovfl_q    <= s1Valid_q ? ovfl_d : '0;
      error_q   <= s1Valid_q && (|ovfl_d);
    end
  end

  // Status: a consumed erroneous result takes priority over clr_err, so a
  // coincident clear restarts the count at one instead of zero.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (consume && error_q) begin
      sticky_d = 1'b1;
      if (clr_err)              count_d = CNT_W'(1);
      else if (count_q != '1)   count_d = count_q + CNT_W'(1);
    end else if (clr_err) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign out_valid  = s2Valid_q;
  assign Sum        = sum_q;
  assign lane_ovfl  = ovfl_q;
  assign Error      = error_q;
  assign err_sticky = sticky_q;
  assign ovfl_count = count_q;

endmodule

// File: tb/tb_psa_simd_pipe.sv
// tb_psa_simd_pipe: self-checking bench for psa_simd_pipe (WIDTH=16, CNT_W=8).
// Expected lane results come from signed integer arithmetic per lane; a
// scoreboard queue holds them in acceptance order, and a negedge process
// compares outputs and status every cycle.
module tb_psa_simd_pipe;

  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int NSL  = W / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A, B;
  logic [1:0]    mode;
  logic          sub, sat;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Sum;
  logic [NSL-1:0] lane_ovfl;
  logic          Error;
  logic          err_sticky;
  logic [CW-1:0] ovfl_count;
  logic          clr_err;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;
  bit bgRun   = 1'b0;

  typedef struct {
    logic [W-1:0]   sum;
    logic [NSL-1:0] ovf;
    logic           err;
  } expT;

  expT expQ[$];

  logic          mSticky = 1'b0;
  logic [CW-1:0] mCount  = '0;

  psa_simd_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
    .lane_ovfl(lane_ovfl), .Error(Error), .err_sticky(err_sticky),
    .ovfl_count(ovfl_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: each lane treated as signed integers, ideal result checked against range.
  function automatic expT modelTxn(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] m, input logic s, input logic st);
    expT r;
    int lw;
    longint sa, sb, ideal, maxV, minV, res;
    logic [63:0] resBits;
    bit ovf;
    lw = (m == 2'b10) ? 16 : (m == 2'b01) ? 8 : 4;
    r.sum = '0;
    r.ovf = '0;
    for (int base = 0; base < W; base += lw) begin
      sa = 0;
      sb = 0;
      for (int k = 0; k < lw; k++) begin
        sa += longint'(a[base+k]) << k;
        sb += longint'(b[base+k]) << k;
      end
      if (sa >= (64'sd1 << (lw - 1))) sa -= (64'sd1 << lw);
      if (sb >= (64'sd1 << (lw - 1))) sb -= (64'sd1 << lw);
      ideal = s ? sa - sb : sa + sb;
      maxV  = (64'sd1 << (lw - 1)) - 1;
      minV  = -(64'sd1 << (lw - 1));
      ovf   = (ideal > maxV) || (ideal < minV);
      res   = ideal;
      if (ovf && st) res = (ideal > maxV) ? maxV : minV;
      resBits = res;
      for (int k = 0; k < lw; k++) r.sum[base+k] = resBits[k];
      if (ovf) for (int k = base / 4; k < (base + lw) / 4; k++) r.ovf[k] = 1'b1;
    end
    r.err = |r.ovf;
    return r;
  endfunction

  // Present one transaction and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] m, input logic s, input logic st);
    bit accepted;
    int waitCnt;
    accepted = 1'b0;
    waitCnt  = 0;
    A = a; B = b; mode = m; sub = s; sat = st;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      accepted = in_ready && !rst;
      @(posedge clk);
      #1;
      waitCnt++;
    end while (!accepted && waitCnt < 200);
    if (accepted) expQ.push_back(modelTxn(a, b, m, s, st));
    else checkOutput("accept timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain timeout", expQ.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] m, input logic s, input logic st,
                             input logic [W-1:0] expSum, input logic [NSL-1:0] expOvf, input logic expErr);
    applyStimulus(a, b, m, s, st);
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid"}, out_valid, 1);
    checkOutput({name, " Sum"}, Sum, expSum);
    checkOutput({name, " lane_ovfl"}, lane_ovfl, expOvf);
    checkOutput({name, " Error"}, Error, expErr);
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare and status model update.
  always @(negedge clk) begin
    expT e;
    if (checkEn) begin
      checkOutput("err_sticky", err_sticky, mSticky);
      checkOutput("ovfl_count", ovfl_count, mCount);
      checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected out_valid", 32'd1, 32'd0);
        end else begin
          e = expQ[0];
          checkOutput("scoreboard Sum", Sum, e.sum);
          checkOutput("scoreboard lane_ovfl", lane_ovfl, e.ovf);
          checkOutput("scoreboard Error", Error, e.err);
        end
      end else begin
        checkOutput("idle Error", Error, 0);
      end
    end
    if (rst) begin
      expQ.delete();
      mSticky = 1'b0;
      mCount  = '0;
    end else if (out_valid && out_ready && expQ.size() > 0) begin
      e = expQ.pop_front();
      if (e.err) begin
        mSticky = 1'b1;
        if (clr_err)           mCount = 1;
        else if (mCount != '1) mCount = mCount + 1;
      end else if (clr_err) begin
        mSticky = 1'b0;
        mCount  = '0;
      end
    end else if (clr_err) begin
      mSticky = 1'b0;
      mCount  = '0;
    end
  end

  initial begin
    expT p;
    logic [W-1:0] held;
    int n;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; mode = '0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset Sum", Sum, 0);
    checkOutput("reset lane_ovfl", lane_ovfl, 0);
    checkOutput("reset Error", Error, 0);
    checkOutput("reset err_sticky", err_sticky, 0);
    checkOutput("reset ovfl_count", ovfl_count, 0);
    checkOutput("reset in_ready", in_ready, 1);
    rst = 1'b0;
    checkEn = 1'b1;

    // Pin the reference model with hand-computed values.
    p = modelTxn(16'h7777, 16'h1111, 2'b00, 1'b0, 1'b0);
    checkOutput("model 4b wrap", {p.sum, p.ovf}, {16'h8888, 4'b1111});
    p = modelTxn(16'h7F01, 16'h0101, 2'b01, 1'b0, 1'b1);
    checkOutput("model 8b sat", {p.sum, p.ovf}, {16'h7F02, 4'b1100});
    p = modelTxn(16'h8000, 16'h0001, 2'b10, 1'b1, 1'b1);
    checkOutput("model 16b sub sat", {p.sum, p.ovf}, {16'h8000, 4'b1111});

    // Directed cases with literal expectations.
    runDirected("t1 4b wrap", 16'h7777, 16'h1111, 2'b00, 1'b0, 1'b0, 16'h8888, 4'b1111, 1'b1);
    checkOutput("t1 err_sticky", err_sticky, 1);
    checkOutput("t1 ovfl_count", ovfl_count, 1);
    runDirected("t1 4b sat", 16'h7777, 16'h1111, 2'b00, 1'b0, 1'b1, 16'h7777, 4'b1111, 1'b1);
    runDirected("t2 8b wrap", 16'h7F01, 16'h0101, 2'b01, 1'b0, 1'b0, 16'h8002, 4'b1100, 1'b1);
    runDirected("t2 8b sat", 16'h7F01, 16'h0101, 2'b01, 1'b0, 1'b1, 16'h7F02, 4'b1100, 1'b1);
    runDirected("t3 16b sub wrap", 16'h8000, 16'h0001, 2'b10, 1'b1, 1'b0, 16'h7FFF, 4'b1111, 1'b1);
    runDirected("t3 16b sub sat", 16'h8000, 16'h0001, 2'b10, 1'b1, 1'b1, 16'h8000, 4'b1111, 1'b1);
    runDirected("t3 16b no ovfl", 16'h1234, 16'h0234, 2'b10, 1'b1, 1'b0, 16'h1000, 4'b0000, 1'b0);
    runDirected("t6 mode11", 16'h7777, 16'h1111, 2'b11, 1'b0, 1'b0, 16'h8888, 4'b1111, 1'b1);
    runDirected("sub 4b carry", 16'h0123, 16'h0111, 2'b00, 1'b1, 1'b0, 16'h0012, 4'b0000, 1'b0);

    // Backpressure: four back-to-back transactions, 3-cycle stall once output is valid.
    fork
      begin
        for (int i = 0; i < 4; i++)
          applyStimulus(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end
      begin
        n = 0;
        while (!out_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        checkOutput("stall out_valid seen", out_valid, 1);
        out_ready = 1'b0;
        held = Sum;
        for (int k = 0; k < 3; k++) begin
          #1;
          checkOutput("stall in_ready", in_ready, 0);
          checkOutput("stall Sum held", Sum, held);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drainQueue();

    // Counter saturation with 260 overflowing results.
    for (int i = 0; i < 260; i++) applyStimulus(16'h7777, 16'h1111, 2'b00, 1'b0, 1'b0);
    drainQueue();
    checkOutput("t5 count saturated", ovfl_count, 8'hFF);

    // clr_err coinciding with a counted consumption, then clr_err alone.
    applyStimulus(16'h7777, 16'h1111, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5 clr+event count", ovfl_count, 1);
    checkOutput("t5 clr+event sticky", err_sticky, 1);
    @(posedge clk);
    #1;
    checkOutput("t5 clr alone count", ovfl_count, 0);
    checkOutput("t5 clr alone sticky", err_sticky, 0);
    clr_err = 1'b0;

    // Reset with two transactions in flight.
    applyStimulus(16'h7777, 16'h1111, 2'b00, 1'b0, 1'b0);
    applyStimulus(16'h1111, 16'h7777, 2'b01, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6 out_valid", out_valid, 0);
    checkOutput("t6 Sum", Sum, 0);
    checkOutput("t6 lane_ovfl", lane_ovfl, 0);
    checkOutput("t6 err_sticky", err_sticky, 0);
    checkOutput("t6 ovfl_count", ovfl_count, 0);
    checkOutput("t6 in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("t6 no late out_valid", out_valid, 0);
    end

    // Randomized traffic with random backpressure and occasional clears.
    bgRun = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end
        bgRun = 1'b0;
      end
      begin
        while (bgRun) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          clr_err   = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1;
    clr_err   = 1'b0;
    drainQueue();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
